mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port SOPC memory between the instruction-fetch master (IF, read-only) and the data master (MEM stage, load/store).
- Sits between the CPU core and the memory, and generates the stall requests consumed by the pipeline ctrl block.
- Data accesses have fixed priority, with a starvation guard so fetch is never locked out. A timeout turns a hung memory into an error response.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte selects = DW/8)
- STARVE_MAX, 4, consecutive contended DM grants before IF is forced to win once
- TIMEOUT, 16, BUSY cycles without mem_ack before the access is aborted with an error

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1)
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  qualifies if_ack: access timed out
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = store
- dm_sel  in  DW/8  byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data
- dm_ack  out  1  one-cycle completion pulse
- dm_err  out  1  qualifies dm_ack: access timed out
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_sel  out  DW/8  byte enables
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data
- mem_ack  in  1  memory done (may be same cycle as mem_ce)
- stallreq_if  out  1  = if_req & ~if_ack (combinational)
- stallreq_dm  out  1  = dm_req & ~dm_ack (combinational)

Behaviour:
- FSM states: IDLE, BUSY, RESP. Registers: grant owner (IF/DM), latched request fields, rdata, err, starve_cnt, tmo_cnt.
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs 0: mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, acks, errs, rdata.
  - starve_cnt = 0, tmo_cnt = 0.
  - Reset mid-BUSY drops mem_ce on the following edge. No ack is issued for the aborted access.
- IDLE, arbitration at the edge:
  - Both requests pending and starve_cnt == STARVE_MAX: grant IF, clear starve_cnt.
  - Otherwise, if dm_req: grant DM. If if_req was also high, starve_cnt += 1 (saturating at STARVE_MAX).
  - Otherwise, if if_req alone: grant IF, clear starve_cnt.
  - On any grant: latch the request fields into the mem_* registers, then go to BUSY.
- BUSY:
  - mem_ce = 1; the mem_* outputs come from the latched values and are stable for the whole access.
  - IF grant drives mem_we = 0 and mem_sel all ones.
  - tmo_cnt increments each BUSY cycle.
  - mem_ack = 1: latch mem_rdata (0 for a store), err = 0, go to RESP.
  - tmo_cnt == TIMEOUT-1 with no ack: err = 1, rdata = 0, go to RESP.
  - mem_ce deasserts on leaving BUSY.
- RESP:
  - Exactly one cycle.
  - Owner's ack = 1; *_rdata/*_err valid only in this cycle.
  - Then go to IDLE and clear tmo_cnt.
  - The master may keep req high to issue its next access, which is arbitrated in IDLE.
- Latency: request seen at edge N gives mem_ce in cycle N+1. A zero-wait memory gives ack in cycle N+2. The next grant happens at the earliest at the edge ending cycle N+3.
- Boundary conditions:
  - mem_ack in IDLE/RESP is ignored.
  - A request dropped while not yet granted is simply not served.
  - Request inputs changing during BUSY have no effect, because the fields were latched.

Decomposition:
- Shared defines (defines file): `RstEnable/`RstDisable, the state encodings, and owner codes OWN_IF/OWN_DM.
- Natural sub-module: mem_arb_prio. It is the registered starve_cnt plus the combinational winner select, taking if_req, dm_req and outputting grant_if/grant_dm.

Test Plan:
- Only if_req=1, addr 0x100, memory acks 0-wait with 0xDEADBEEF:
  - mem_ce=1, mem_addr=0x100, mem_we=0 in cycle 1.
  - if_ack=1, if_rdata=0xDEADBEEF, if_err=0 in cycle 2.
  - stallreq_if high in cycles 0–1.
- Store, dm_req=1, we=1, sel=4'b0011, addr 0x200, data 0x1234 → mem_we=1, mem_sel=0011, mem_wdata=0x1234; dm_ack one cycle after mem_ack.
- Both requests held continuously, memory 0-wait:
  - Grant sequence DM,DM,DM,DM,IF, then repeating (STARVE_MAX=4).
  - IF gets one ack per 5 accesses.
- Memory never acks on a DM load → mem_ce high exactly 16 cycles, then dm_ack=1 with dm_err=1, dm_rdata=0; the next access proceeds normally.
- rst asserted in the 2nd BUSY cycle of a 3-wait access → mem_ce=0 and all outputs 0 after the edge; no ack; a fresh if_req after reset is served normally.
- A spurious mem_ack pulse in IDLE → no state change, no ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the shared port: data wins, except that fetch is forced through once
// after STARVE_MAX consecutive contended data grants.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_if;

  always_comb begin
    force_if = if_req & dm_req & (starve_cnt_q == CW'(STARVE_MAX));
    grant_if = arb_en & if_req & (force_if | ~dm_req);
    grant_dm = arb_en & dm_req & ~force_if;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_dm && if_req && (starve_cnt_q != CW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data master, with a
// per-access timeout and pipeline stall requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  output logic            if_err,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_sel,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            dm_err,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_sel,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            stallreq_if,
  output logic            stallreq_dm
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  owner_e          owner_q;
  logic            we_q;
  logic [SW-1:0]   sel_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            grant_if, grant_dm, tmo_hit, busy, resp;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (state_q == StIdle),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_if || grant_dm) state_d = StBusy;
      StBusy:  if (mem_ack || tmo_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields are captured at grant so the memory sees a stable access for its duration.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      owner_q   <= OwnIf;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tmo_cnt_q <= '0;
          if (grant_dm) begin
            owner_q <= OwnDm;
            we_q    <= dm_we;
            sel_q   <= dm_sel;
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
          end else if (grant_if) begin
            owner_q <= OwnIf;
            we_q    <= 1'b0;
            sel_q   <= '1;
            addr_q  <= if_addr;
            wdata_q <= '0;
          end
        end
        StBusy: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (mem_ack) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        StResp:  tmo_cnt_q <= '0;
        default: tmo_cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q == StBusy);
    resp        = (state_q == StResp);
    mem_ce      = busy;
    mem_we      = busy & we_q;
    mem_sel     = busy ? sel_q : '0;
    mem_addr    = busy ? addr_q : '0;
    mem_wdata   = busy ? wdata_q : '0;
    if_ack      = resp & (owner_q == OwnIf);
    dm_ack      = resp & (owner_q == OwnDm);
    if_rdata    = if_ack ? rdata_q : '0;
    dm_rdata    = dm_ack ? rdata_q : '0;
    if_err      = if_ack & err_q;
    dm_err      = dm_ack & err_q;
    stallreq_if = if_req & ~if_ack;
    stallreq_dm = dm_req & ~dm_ack;
  end

endmodule
